// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with halt and retire count.
// Define SEQ_TIMEOUT_EN to bound memory waits by TIMEOUT_CYCLES and trap into FAULT.
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic        i_Halt,
    input  logic        i_IMemAck,
    input  logic        i_DMemAck,
    input  logic        i_Branch,
    input  logic        i_Jump,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_RegWrite,
    input  logic        i_BranchTaken,
    output logic        o_IMemReq,
    output logic        o_IRWrite,
    output logic        o_DMemReq,
    output logic        o_DMemWe,
    output logic        o_RegWriteEn,
    output logic        o_PCWrite,
    output logic        o_PCSrc,
    output logic [2:0]  o_State,
    output logic [31:0] o_InstRet,
    output logic        o_Fault
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5,
        FAULT     = 3'd6
    } state_t;

    state_t      state, state_nxt, done_nxt;
    logic [31:0] inst_ret;
    logic        done;
    logic        timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          waiting;

    assign waiting = (state == FETCH && !i_IMemAck) || (state == MEMORY && !i_DMemAck);
    // an ack on the last allowed cycle still wins over the fault
    assign timeout = waiting && wait_cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) wait_cnt <= '0;
        else          wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state    <= FETCH;
            inst_ret <= '0;
        end else begin
            state    <= state_nxt;
            inst_ret <= done ? inst_ret + 32'd1 : inst_ret;
        end
    end

    assign done = (state == EXECUTE && !(i_MemRead || i_MemWrite) && !i_RegWrite)
               || (state == MEMORY && i_DMemAck && !i_MemRead)
               || (state == WRITEBACK);
    assign done_nxt = i_Halt ? HALT : FETCH;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:     state_nxt = i_IMemAck ? DECODE : timeout ? FAULT : FETCH;
            DECODE:    state_nxt = EXECUTE;
            EXECUTE:   state_nxt = (i_MemRead || i_MemWrite) ? MEMORY : i_RegWrite ? WRITEBACK : done_nxt;
            MEMORY:    state_nxt = !i_DMemAck ? (timeout ? FAULT : MEMORY) : i_MemRead ? WRITEBACK : done_nxt;
            WRITEBACK: state_nxt = done_nxt;
            HALT:      state_nxt = i_Halt ? HALT : FETCH;
            FAULT:     state_nxt = FAULT;
            default:   state_nxt = FETCH;
        endcase
    end

    always_comb begin
        o_IMemReq    = state == FETCH;
        o_IRWrite    = state == FETCH && i_IMemAck;
        o_DMemReq    = state == MEMORY;
        o_DMemWe     = state == MEMORY && i_MemWrite;
        o_RegWriteEn = state == WRITEBACK;
        o_PCWrite    = done;
        o_PCSrc      = done && (i_Jump || (i_Branch && i_BranchTaken));
        o_Fault      = state == FAULT;
        o_State      = state;
        o_InstRet    = inst_ret;
    end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven cycle vectors plus directed halt, reset, wrap and timeout sequences.
module tb_core_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        halt, iack, dack, br, jmp, mr, mw, rw, bt;
    logic        imreq, irw, dmreq, dwe, rwe, pcw, pcsrc, fault;
    logic [2:0]  st;
    logic [31:0] instret;
    logic [9:0]  outs;
    int          tests = 0, fails = 0;

    typedef struct {
        logic [8:0] in;   // {halt, iack, dack, br, jmp, mr, mw, rw, bt}
        logic [9:0] exp;  // {state[2:0], imreq, irw, dmreq, dwe, rwe, pcw, pcsrc}
    } vec_t;
    vec_t v[30];

    core_sequencer dut (
        .i_CLK(clk), .i_RST_n(rst_n), .i_Halt(halt), .i_IMemAck(iack), .i_DMemAck(dack),
        .i_Branch(br), .i_Jump(jmp), .i_MemRead(mr), .i_MemWrite(mw), .i_RegWrite(rw),
        .i_BranchTaken(bt), .o_IMemReq(imreq), .o_IRWrite(irw), .o_DMemReq(dmreq),
        .o_DMemWe(dwe), .o_RegWriteEn(rwe), .o_PCWrite(pcw), .o_PCSrc(pcsrc),
        .o_State(st), .o_InstRet(instret), .o_Fault(fault)
    );

    always #5 clk = ~clk;
    assign outs = {st, imreq, irw, dmreq, dwe, rwe, pcw, pcsrc};

    task automatic set_in(input logic [8:0] in);
        {halt, iack, dack, br, jmp, mr, mw, rw, bt} = in;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // R-type with immediate acks
        v[0]  = '{9'b010000010, 10'b000_1100000};
        v[1]  = '{9'b010000010, 10'b001_0000000};
        v[2]  = '{9'b010000010, 10'b010_0000000};
        v[3]  = '{9'b010000010, 10'b100_0000110};
        // load, data ack after 3 wait cycles
        v[4]  = '{9'b010001010, 10'b000_1100000};
        v[5]  = '{9'b010001010, 10'b001_0000000};
        v[6]  = '{9'b010001010, 10'b010_0000000};
        v[7]  = '{9'b010001010, 10'b011_0010000};
        v[8]  = '{9'b010001010, 10'b011_0010000};
        v[9]  = '{9'b010001010, 10'b011_0010000};
        v[10] = '{9'b011001010, 10'b011_0010000};
        v[11] = '{9'b010001010, 10'b100_0000110};
        // store completes on the ack cycle
        v[12] = '{9'b010000100, 10'b000_1100000};
        v[13] = '{9'b010000100, 10'b001_0000000};
        v[14] = '{9'b010000100, 10'b010_0000000};
        v[15] = '{9'b011000100, 10'b011_0011010};
        // taken branch, first fetch cycle without ack
        v[16] = '{9'b000100001, 10'b000_1000000};
        v[17] = '{9'b010100001, 10'b000_1100000};
        v[18] = '{9'b010100001, 10'b001_0000000};
        v[19] = '{9'b010100001, 10'b010_0000011};
        // not-taken branch
        v[20] = '{9'b010100000, 10'b000_1100000};
        v[21] = '{9'b010100000, 10'b001_0000000};
        v[22] = '{9'b010100000, 10'b010_0000010};
        // jump
        v[23] = '{9'b010010000, 10'b000_1100000};
        v[24] = '{9'b010010000, 10'b001_0000000};
        v[25] = '{9'b010010000, 10'b010_0000011};
        // halt outside the completing cycle is ignored
        v[26] = '{9'b110000010, 10'b000_1100000};
        v[27] = '{9'b110000010, 10'b001_0000000};
        v[28] = '{9'b010000010, 10'b010_0000000};
        v[29] = '{9'b010000010, 10'b100_0000110};

        set_in('0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", {22'd0, outs}, {22'd0, 10'b000_1000000});
        check("reset_instret", instret, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            set_in(v[i].in);
            #1;
            check($sformatf("vec%0d", i), {22'd0, outs}, {22'd0, v[i].exp});
            @(negedge clk);
        end
        #1;
        check("table_instret", instret, 32'd7);

        // halt raised during MEMORY: load finishes, then HALT
        set_in(9'b010001010);
        repeat (3) @(negedge clk);
        set_in(9'b100001010);
        #1;
        check("halt_mem_state", {29'd0, st}, 32'd3);
        @(negedge clk);
        set_in(9'b101001010);
        @(negedge clk);
        set_in(9'b100001010);
        #1;
        check("halt_wb", {22'd0, outs}, {22'd0, 10'b100_0000110});
        @(negedge clk);
        #1;
        check("halt_enter", {22'd0, outs}, {22'd0, 10'b101_0000000});
        check("halt_instret", instret, 32'd8);
        @(negedge clk);
        #1;
        check("halt_hold", {29'd0, st}, 32'd5);
        set_in('0);
        @(negedge clk);
        #1;
        check("halt_exit", {22'd0, outs}, {22'd0, 10'b000_1000000});

        // asynchronous reset in the middle of a load
        set_in(9'b010001010);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        set_in(9'b000001010);
        #1;
        check("rst_mid_state", {29'd0, st}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {22'd0, outs}, {22'd0, 10'b000_1000000});
        check("rst_mid_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in('0);
        #1;
        check("rst_first_fetch", {22'd0, outs}, {22'd0, 10'b000_1000000});

        // retire counter wrap using no-op instructions
        force dut.inst_ret = 32'hFFFF_FFFE;
        #1;
        release dut.inst_ret;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFE);
        set_in(9'b010000000);
        repeat (3) @(negedge clk);
        #1;
        check("wrap_max", instret, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        #1;
        check("wrap_zero", instret, 32'd0);

        set_in('0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SEQ_TIMEOUT_EN
        repeat (15) @(negedge clk);
        #1;
        check("to_wait15", {29'd0, st}, 32'd0);
        @(negedge clk);
        #1;
        check("to_fault_state", {22'd0, outs}, {22'd0, 10'b110_0000000});
        check("to_fault_flag", {31'd0, fault}, 32'd1);
        set_in(9'b011000010);
        @(negedge clk);
        #1;
        check("to_fault_sticky", {22'd0, outs}, {22'd0, 10'b110_0000000});
        set_in('0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        set_in(9'b010000010);
        @(negedge clk);
        #1;
        check("to_late_ack", {29'd0, st}, 32'd1);
        check("to_late_fault", {31'd0, fault}, 32'd0);
`else
        repeat (20) @(negedge clk);
        #1;
        check("unbounded_state", {29'd0, st}, 32'd0);
        check("unbounded_fault", {31'd0, fault}, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
